// File: rtl/bp_be_dcache_port_arbiter.sv
// Arbitrates the single D$ request port between the memory pipe (port 0)
// and the page-table walker (port 1). Each request is issued in EX1. Its ptag
// is muxed in EX2, and its EX3 response is routed back to the requester that
// issued it. Ownership changes only after the in-flight stages have drained.
//
// Handshake: a requester's packet is accepted in any cycle where its
// *_v_i and *_ready_o are both high. Ready does not depend on valid. An
// accepted packet appears on dcache_v_o/dcache_pkt_o in that same cycle.
module bp_be_dcache_port_arbiter #(
  parameter int dcache_pkt_width_p = 81,
  parameter int ptag_width_p       = 28,
  parameter int dword_width_p      = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          flush_i,

  input  logic                          pipe_v_i,
  input  logic [dcache_pkt_width_p-1:0] pipe_pkt_i,
  input  logic [ptag_width_p-1:0]       pipe_ptag_i,
  input  logic                          pipe_ptag_v_i,
  output logic                          pipe_ready_o,
  output logic                          pipe_data_v_o,
  output logic [dword_width_p-1:0]      pipe_data_o,

  input  logic                          ptw_busy_i,
  input  logic                          ptw_v_i,
  input  logic [dcache_pkt_width_p-1:0] ptw_pkt_i,
  input  logic [ptag_width_p-1:0]       ptw_ptag_i,
  input  logic                          ptw_ptag_v_i,
  output logic                          ptw_ready_o,
  output logic                          ptw_data_v_o,
  output logic [dword_width_p-1:0]      ptw_data_o,

  output logic                          dcache_v_o,
  output logic [dcache_pkt_width_p-1:0] dcache_pkt_o,
  output logic [ptag_width_p-1:0]       dcache_ptag_o,
  output logic                          dcache_ptag_v_o,
  input  logic                          dcache_ready_i,
  input  logic                          dcache_v_i,
  input  logic [dword_width_p-1:0]      dcache_data_i,
  input  logic                          dcache_miss_i,

  output logic [1:0]                    owner_o
);

  typedef enum logic [1:0] {
    ST_PIPE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_PTW   = 2'b10
  } state_e;

  state_e state_q, state_d;

  // live_q is low during reset and for the cycle in which reset is released.
  // Every ready and data output is qualified by it, so all outputs read zero
  // while reset is held. The reset net is not used as a combinational signal.
  logic live_q;

  // Ownership pipe. s1 is the EX2 stage and s2 is the EX3 stage. own: 0 = pipe, 1 = ptw.
  logic s1_v_q, s1_own_q;
  logic s2_v_q, s2_own_q, s2_kill_q;

  logic pipe_ready, ptw_ready;
  logic pipe_fire, ptw_fire;
  logic s1_kill, s2_kill;
  logic in_flight;

  // Issue qualification. A flush blocks a new pipe issue in the same cycle.
  always_comb begin
    pipe_ready = live_q & (state_q == ST_PIPE) & dcache_ready_i & ~ptw_busy_i
               & ~dcache_miss_i & ~flush_i;
    ptw_ready  = live_q & (state_q == ST_PTW) & dcache_ready_i & ~dcache_miss_i;
    pipe_fire  = pipe_v_i & pipe_ready;
    ptw_fire   = ptw_v_i & ptw_ready;
    in_flight  = s1_v_q | s2_v_q;
    // A flush kills pipe-owned entries in the cycle it arrives.
    // PTW entries are never killed.
    s1_kill    = flush_i & s1_v_q & ~s1_own_q;
    s2_kill    = s2_kill_q | (flush_i & s2_v_q & ~s2_own_q);
  end

  // Ownership handover. DRAIN exits only once both tracked stages are empty.
  // The exit target follows ptw_busy_i as sampled on the exit cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PIPE:  if (ptw_busy_i) state_d = ST_DRAIN;
      ST_DRAIN: if (!in_flight) state_d = ptw_busy_i ? ST_PTW : ST_PIPE;
      ST_PTW:   if (!ptw_busy_i) state_d = ST_DRAIN;
      default:  state_d = ST_PIPE;
    endcase
  end

  // State register and ownership pipe. An asynchronous reset discards all in-flight ownership.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_PIPE;
      live_q    <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_own_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_own_q  <= 1'b0;
      s2_kill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      s1_v_q    <= pipe_fire | ptw_fire;
      s1_own_q  <= ptw_fire;
      s2_v_q    <= s1_v_q;
      s2_own_q  <= s1_own_q;
      s2_kill_q <= s1_kill;
    end
  end

  // Output muxing. The ptag is selected by the owner of the request in EX2, not by the current state.
  always_comb begin
    pipe_ready_o    = pipe_ready;
    ptw_ready_o     = ptw_ready;
    dcache_v_o      = pipe_fire | ptw_fire;
    dcache_pkt_o    = '0;
    if (ptw_fire)       dcache_pkt_o = ptw_pkt_i;
    else if (pipe_fire) dcache_pkt_o = pipe_pkt_i;
    dcache_ptag_o   = live_q ? (s1_own_q ? ptw_ptag_i : pipe_ptag_i) : '0;
    dcache_ptag_v_o = s1_v_q & (s1_own_q ? ptw_ptag_v_i : pipe_ptag_v_i) & ~s1_kill;
    pipe_data_v_o   = s2_v_q & ~s2_own_q & ~s2_kill & dcache_v_i;
    ptw_data_v_o    = s2_v_q & s2_own_q & dcache_v_i;
    pipe_data_o     = live_q ? dcache_data_i : '0;
    ptw_data_o      = live_q ? dcache_data_i : '0;
    owner_o         = state_q;
  end

endmodule

// File: tb/tb_bp_be_dcache_port_arbiter.sv
// Bench for bp_be_dcache_port_arbiter. Directed scenarios run first, each
// with hand-computed literal expectations. A randomized run follows. A
// behavioural model that tracks requests by issue age checks every cycle.
module tb_bp_be_dcache_port_arbiter;

  localparam int PW = 81;
  localparam int TW = 28;
  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic reset_n_i;

  // ---------------- DUT signals ----------------
  logic          flush_i;
  logic          pipe_v_i, pipe_ptag_v_i, pipe_ready_o, pipe_data_v_o;
  logic [PW-1:0] pipe_pkt_i;
  logic [TW-1:0] pipe_ptag_i;
  logic [DW-1:0] pipe_data_o;
  logic          ptw_busy_i, ptw_v_i, ptw_ptag_v_i, ptw_ready_o, ptw_data_v_o;
  logic [PW-1:0] ptw_pkt_i;
  logic [TW-1:0] ptw_ptag_i;
  logic [DW-1:0] ptw_data_o;
  logic          dcache_v_o, dcache_ptag_v_o, dcache_ready_i, dcache_v_i, dcache_miss_i;
  logic [PW-1:0] dcache_pkt_o;
  logic [TW-1:0] dcache_ptag_o;
  logic [DW-1:0] dcache_data_i;
  logic [1:0]    owner_o;

  bp_be_dcache_port_arbiter #(
    .dcache_pkt_width_p(PW), .ptag_width_p(TW), .dword_width_p(DW)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
    .pipe_v_i(pipe_v_i), .pipe_pkt_i(pipe_pkt_i), .pipe_ptag_i(pipe_ptag_i),
    .pipe_ptag_v_i(pipe_ptag_v_i), .pipe_ready_o(pipe_ready_o),
    .pipe_data_v_o(pipe_data_v_o), .pipe_data_o(pipe_data_o),
    .ptw_busy_i(ptw_busy_i), .ptw_v_i(ptw_v_i), .ptw_pkt_i(ptw_pkt_i),
    .ptw_ptag_i(ptw_ptag_i), .ptw_ptag_v_i(ptw_ptag_v_i), .ptw_ready_o(ptw_ready_o),
    .ptw_data_v_o(ptw_data_v_o), .ptw_data_o(ptw_data_o),
    .dcache_v_o(dcache_v_o), .dcache_pkt_o(dcache_pkt_o), .dcache_ptag_o(dcache_ptag_o),
    .dcache_ptag_v_o(dcache_ptag_v_o), .dcache_ready_i(dcache_ready_i),
    .dcache_v_i(dcache_v_i), .dcache_data_i(dcache_data_i),
    .dcache_miss_i(dcache_miss_i), .owner_o(owner_o)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // age_v[k]/age_own[k] describe the request issued k+1 cycles ago.
  // age1_killed marks a pipe request flushed while it was one cycle old.
  // m_mode: 0 = pipe owns the port, 1 = handover in progress, 2 = ptw owns it.
  logic age_v[2];
  logic age_own[2];
  logic age1_killed;
  logic m_live;
  int   m_mode;

  task automatic model_reset();
    age_v[0] = 1'b0; age_v[1] = 1'b0;
    age_own[0] = 1'b0; age_own[1] = 1'b0;
    age1_killed = 1'b0;
    m_live = 1'b0;
    m_mode = 0;
  endtask

  // Check every output against the rules for the inputs of the current cycle.
  // Then advance the model across the coming clock edge.
  task automatic model_step();
    logic pr, tr, pf, tf, k0, k1;
    int nm;
    pr = m_live && m_mode == 0 && dcache_ready_i && !ptw_busy_i && !dcache_miss_i && !flush_i;
    tr = m_live && m_mode == 2 && dcache_ready_i && !dcache_miss_i;
    pf = pipe_v_i & pr;
    tf = ptw_v_i & tr;
    chk("pipe_ready", pipe_ready_o, pr);
    chk("ptw_ready", ptw_ready_o, tr);
    chk("dcache_v", dcache_v_o, pf | tf);
    if (pf | tf) chk("dcache_pkt", dcache_pkt_o, tf ? ptw_pkt_i : pipe_pkt_i);
    k0 = flush_i & ~age_own[0];
    chk("ptag_v", dcache_ptag_v_o,
        age_v[0] & (age_own[0] ? ptw_ptag_v_i : pipe_ptag_v_i) & ~k0);
    if (age_v[0]) chk("ptag", dcache_ptag_o, age_own[0] ? ptw_ptag_i : pipe_ptag_i);
    k1 = age1_killed | (flush_i & ~age_own[1]);
    chk("pipe_data_v", pipe_data_v_o, age_v[1] & ~age_own[1] & ~k1 & dcache_v_i);
    chk("ptw_data_v", ptw_data_v_o, age_v[1] & age_own[1] & dcache_v_i);
    chk("pipe_data", pipe_data_o, m_live ? dcache_data_i : 64'd0);
    chk("ptw_data", ptw_data_o, m_live ? dcache_data_i : 64'd0);
    chk("owner", owner_o, m_mode);
    nm = m_mode;
    if (m_mode == 0 && ptw_busy_i) nm = 1;
    else if (m_mode == 2 && !ptw_busy_i) nm = 1;
    else if (m_mode == 1 && !age_v[0] && !age_v[1]) nm = ptw_busy_i ? 2 : 0;
    m_mode = nm;
    age1_killed = age_v[0] & k0;
    age_v[1] = age_v[0];  age_own[1] = age_own[0];
    age_v[0] = pf | tf;   age_own[0] = tf;
    m_live = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flush_i = 0; pipe_v_i = 0; pipe_ptag_v_i = 0; pipe_ptag_i = '0; pipe_pkt_i = '0;
    ptw_busy_i = 0; ptw_v_i = 0; ptw_ptag_v_i = 0; ptw_ptag_i = '0; ptw_pkt_i = '0;
    dcache_ready_i = 1; dcache_v_i = 0; dcache_data_i = '0; dcache_miss_i = 0;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic next_cycle();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_inputs(input logic busy_now);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    pipe_pkt_i = r[PW-1:0];
    r = {$urandom, $urandom, $urandom};
    ptw_pkt_i = r[PW-1:0];
    r[31:0] = $urandom; pipe_ptag_i = r[TW-1:0];
    r[31:0] = $urandom; ptw_ptag_i = r[TW-1:0];
    pipe_v_i       = $urandom_range(0, 1) == 1;
    ptw_v_i        = $urandom_range(0, 1) == 1;
    pipe_ptag_v_i  = $urandom_range(0, 3) != 0;
    ptw_ptag_v_i   = $urandom_range(0, 3) != 0;
    flush_i        = $urandom_range(0, 7) == 0;
    dcache_miss_i  = $urandom_range(0, 5) == 0;
    dcache_ready_i = $urandom_range(0, 7) != 0;
    dcache_v_i     = $urandom_range(0, 3) != 0;
    dcache_data_i  = {$urandom, $urandom};
    ptw_busy_i     = busy_now;
  endtask

  // ---------------- stimulus ----------------
  logic [PW-1:0] pkt_a, pkt_b;
  logic busy_r;

  initial begin
    pkt_a = '0; pkt_a[40:0] = 41'h1_2345_6789_A;
    pkt_b = '0; pkt_b[80:60] = 21'h1B_EEF;
    idle_inputs();
    model_reset();
    reset_n_i = 1'b0;
    pipe_v_i = 1;
    #12;
    // Reset state: the pipe is presenting a request and nothing may be issued.
    chk("rst_pipe_ready", pipe_ready_o, 1'b0);
    chk("rst_dcache_v", dcache_v_o, 1'b0);
    chk("rst_owner", owner_o, 2'b00);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    idle_inputs();
    settle(); next_cycle();

    // 1: pipe load round trip
    idle_inputs(); pipe_v_i = 1; pipe_pkt_i = pkt_a;
    settle(); chk("t1_issue_v", dcache_v_o, 1'b1); chk("t1_pkt", dcache_pkt_o, pkt_a); next_cycle();
    idle_inputs(); pipe_ptag_i = 28'h123; pipe_ptag_v_i = 1;
    settle(); chk("t1_ptag_v", dcache_ptag_v_o, 1'b1); chk("t1_ptag", dcache_ptag_o, 28'h123); next_cycle();
    idle_inputs(); dcache_v_i = 1; dcache_data_i = 64'hDEAD;
    settle(); chk("t1_pipe_dv", pipe_data_v_o, 1'b1); chk("t1_pipe_data", pipe_data_o, 64'hDEAD);
    chk("t1_ptw_dv", ptw_data_v_o, 1'b0); next_cycle();

    // 2: handover to PTW while a pipe request is in flight
    idle_inputs(); pipe_v_i = 1; settle(); next_cycle();
    idle_inputs(); pipe_v_i = 1; ptw_busy_i = 1;
    settle(); chk("t2_busy_blocks", pipe_ready_o, 1'b0); chk("t2_no_issue", dcache_v_o, 1'b0); next_cycle();
    idle_inputs(); ptw_busy_i = 1; dcache_v_i = 1; dcache_data_i = 64'h77;
    settle(); chk("t2_owner_t2", owner_o, 2'b01); chk("t2_pipe_dv", pipe_data_v_o, 1'b1); next_cycle();
    idle_inputs(); ptw_busy_i = 1;
    settle(); chk("t2_owner_t3", owner_o, 2'b01); next_cycle();
    idle_inputs(); ptw_busy_i = 1;
    settle(); chk("t2_owner_t4", owner_o, 2'b10); chk("t2_ptw_ready", ptw_ready_o, 1'b1); next_cycle();

    // 3: PTW request round trip
    idle_inputs(); ptw_busy_i = 1; ptw_v_i = 1; ptw_pkt_i = pkt_b;
    settle(); chk("t3_issue_v", dcache_v_o, 1'b1); chk("t3_pkt", dcache_pkt_o, pkt_b); next_cycle();
    idle_inputs(); ptw_busy_i = 1; ptw_ptag_i = 28'h456; ptw_ptag_v_i = 1;
    settle(); chk("t3_ptag_v", dcache_ptag_v_o, 1'b1); chk("t3_ptag", dcache_ptag_o, 28'h456); next_cycle();
    idle_inputs(); ptw_busy_i = 1; dcache_v_i = 1; dcache_data_i = 64'h1F;
    settle(); chk("t3_ptw_dv", ptw_data_v_o, 1'b1); chk("t3_ptw_data", ptw_data_o, 64'h1F);
    chk("t3_pipe_dv", pipe_data_v_o, 1'b0); next_cycle();
    idle_inputs(); settle(); next_cycle();
    idle_inputs(); settle(); chk("t3_owner_drain", owner_o, 2'b01); next_cycle();
    idle_inputs(); settle(); chk("t3_owner_back", owner_o, 2'b00); next_cycle();

    // 4: flush kills a pipe request in flight
    idle_inputs(); pipe_v_i = 1; settle(); next_cycle();
    idle_inputs(); flush_i = 1; pipe_ptag_v_i = 1; pipe_v_i = 1;
    settle(); chk("t4_ptag_v", dcache_ptag_v_o, 1'b0); chk("t4_flush_blocks", dcache_v_o, 1'b0); next_cycle();
    idle_inputs(); dcache_v_i = 1; dcache_data_i = 64'h55;
    settle(); chk("t4_pipe_dv", pipe_data_v_o, 1'b0); next_cycle();

    // 5: miss holds off issue
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); dcache_miss_i = 1; pipe_v_i = 1;
      settle(); chk("t5_ready", pipe_ready_o, 1'b0); chk("t5_dcache_v", dcache_v_o, 1'b0); next_cycle();
    end
    idle_inputs(); pipe_v_i = 1;
    settle(); chk("t5_issue_after", dcache_v_o, 1'b1); next_cycle();
    idle_inputs(); settle(); next_cycle();
    idle_inputs(); settle(); next_cycle();

    // randomized traffic; ptw_busy_i toggles occasionally so each owner holds for a while
    busy_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) busy_r = ~busy_r;
      rand_inputs(busy_r);
      settle(); next_cycle();
    end

    // 6: asynchronous reset in the middle of a walk
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); ptw_busy_i = 1; settle(); next_cycle();
    end
    idle_inputs(); ptw_busy_i = 1;
    settle(); chk("t6_in_ptw", owner_o, 2'b10); next_cycle();
    idle_inputs(); ptw_busy_i = 1; ptw_v_i = 1; settle(); next_cycle();
    idle_inputs(); ptw_busy_i = 1; ptw_v_i = 1; ptw_ptag_v_i = 1; pipe_v_i = 1;
    dcache_v_i = 1; dcache_data_i = 64'hABC;
    settle();
    chk("t6_pre_ptag_v", dcache_ptag_v_o, 1'b1);
    reset_n_i = 1'b0;
    #1;
    chk("t6_ptw_ready", ptw_ready_o, 1'b0);
    chk("t6_pipe_ready", pipe_ready_o, 1'b0);
    chk("t6_dcache_v", dcache_v_o, 1'b0);
    chk("t6_ptag_v", dcache_ptag_v_o, 1'b0);
    chk("t6_ptw_dv", ptw_data_v_o, 1'b0);
    chk("t6_pipe_dv", pipe_data_v_o, 1'b0);
    chk("t6_ptw_data", ptw_data_o, 64'd0);
    chk("t6_pipe_data", pipe_data_o, 64'd0);
    chk("t6_owner", owner_o, 2'b00);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    model_reset();
    idle_inputs(); dcache_v_i = 1; dcache_data_i = 64'hABC;
    settle(); chk("t6_post_owner", owner_o, 2'b00); next_cycle();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); dcache_v_i = 1; dcache_data_i = 64'hABC;
      settle(); chk("t6_no_stray_ptw", ptw_data_v_o, 1'b0); next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
